// File: rtl/pc_flow_ctrl.sv
// Multi-cycle PC flow controller: fetch sequencing, branch/jump resolution,
// datapath wait and exception vectoring. Strobes are decoded from the current
// state and inputs; only the exception vector address is held in a register.
module pc_flow_ctrl #(
    parameter logic [7:0] EXC_ILLEGAL_ADDR = 8'd253,
    parameter logic [7:0] EXC_OVF_ADDR     = 8'd254,
    parameter logic [7:0] EXC_DIV0_ADDR    = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       gt,
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       op_done,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       epc_write,
    output logic       link_write,
    output logic [7:0] exc_addr
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned ADDR_W = 8;

    // PC mux selections
    localparam logic [SRC_W-1:0] SRC_PC4    = 3'b000;
    localparam logic [SRC_W-1:0] SRC_BRANCH = 3'b001;
    localparam logic [SRC_W-1:0] SRC_JUMP   = 3'b010;
    localparam logic [SRC_W-1:0] SRC_EPC    = 3'b011;
    localparam logic [SRC_W-1:0] SRC_VECTOR = 3'b100;
    localparam logic [SRC_W-1:0] SRC_REG_A  = 3'b101;

    // Opcodes and R-type functs with flow-control meaning
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_BLE   = 6'h06;
    localparam logic [OP_W-1:0] OP_BGT   = 6'h07;
    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_RTE   = 6'h13;

    typedef enum logic [3:0] {
        FETCH0   = 4'd0,
        FETCH1   = 4'd1,
        FETCH2   = 4'd2,
        DECODE   = 4'd3,
        EXEC     = 4'd4,
        WAIT_OP  = 4'd5,
        EXC_EPC  = 4'd6,
        EXC_WAIT = 4'd7,
        EXC_LOAD = 4'd8
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   exc_addr_q, exc_addr_d;

    // State and exception vector registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH0;
            exc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // Next-state and strobe decode; reset suppresses every strobe
    always_comb begin
        state_d    = state_q;
        exc_addr_d = exc_addr_q;
        pc_source  = SRC_PC4;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        epc_write  = 1'b0;
        link_write = 1'b0;

        case (state_q)
            FETCH0: begin
                mem_read = 1'b1;
                state_d  = FETCH1;
            end
            FETCH1: begin
                mem_read = 1'b1;
                state_d  = FETCH2;
            end
            FETCH2: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                pc_source = SRC_PC4;
                state_d   = DECODE;
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH0;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_write  = 1'b1;
                            pc_source = SRC_REG_A;
                        end else if (funct == FN_RTE) begin
                            pc_write  = 1'b1;
                            pc_source = SRC_EPC;
                        end else begin
                            state_d = WAIT_OP;
                        end
                    end
                    OP_J: begin
                        pc_write  = 1'b1;
                        pc_source = SRC_JUMP;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = SRC_JUMP;
                        link_write = 1'b1;
                    end
                    OP_BEQ, OP_BNE, OP_BLE, OP_BGT: begin
                        // Untaken branches leave the PC at PC+4 from FETCH2
                        if (((opcode == OP_BEQ) &&  zero) ||
                            ((opcode == OP_BNE) && !zero) ||
                            ((opcode == OP_BLE) && !gt)   ||
                            ((opcode == OP_BGT) &&  gt)) begin
                            pc_write  = 1'b1;
                            pc_source = SRC_BRANCH;
                        end
                    end
                    6'h08, 6'h09, 6'h0a, 6'h0f,
                    6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b: begin
                        state_d = WAIT_OP;
                    end
                    default: begin
                        exc_addr_d = EXC_ILLEGAL_ADDR;
                        state_d    = EXC_EPC;
                    end
                endcase
            end
            WAIT_OP: begin
                if (overflow) begin
                    exc_addr_d = EXC_OVF_ADDR;
                    state_d    = EXC_EPC;
                end else if (div_zero) begin
                    exc_addr_d = EXC_DIV0_ADDR;
                    state_d    = EXC_EPC;
                end else if (op_done) begin
                    state_d = FETCH0;
                end
            end
            EXC_EPC: begin
                epc_write = 1'b1;
                mem_read  = 1'b1;
                state_d   = EXC_WAIT;
            end
            EXC_WAIT: begin
                mem_read = 1'b1;
                state_d  = EXC_LOAD;
            end
            EXC_LOAD: begin
                pc_write  = 1'b1;
                pc_source = SRC_VECTOR;
                state_d   = FETCH0;
            end
            default: begin
                state_d = FETCH0;
            end
        endcase

        if (reset) begin
            pc_source  = SRC_PC4;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            epc_write  = 1'b0;
            link_write = 1'b0;
        end
    end

    assign exc_addr = exc_addr_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed literal sequences followed by randomized
// instructions checked against an instruction-level expectation builder.
module tb_pc_flow_ctrl;

    typedef struct packed {
        logic [2:0] src;
        logic       pcw;
        logic       irw;
        logic       mr;
        logic       epcw;
        logic       lnk;
        logic [7:0] exc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, gt, overflow, div_zero, op_done;
    logic [2:0] pc_source;
    logic       pc_write, ir_write, mem_read, epc_write, link_write;
    logic [7:0] exc_addr;

    pc_flow_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .gt(gt), .overflow(overflow), .div_zero(div_zero),
        .op_done(op_done), .pc_source(pc_source), .pc_write(pc_write),
        .ir_write(ir_write), .mem_read(mem_read), .epc_write(epc_write),
        .link_write(link_write), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    failed = 0;
    int    cycle_no = 0;
    bit    exp_valid = 1'b0;
    exp_t  exp_cur;
    string tag = "";

    // Model state: vector address currently held, and abort bookkeeping
    logic [7:0] exc_model = 8'd0;
    int         cur_idx;
    int         cur_abort;
    bit         aborted;

    function automatic exp_t mk(input logic [2:0] src, input logic pcw, input logic irw,
                                input logic mr, input logic epcw, input logic lnk,
                                input logic [7:0] exc);
        exp_t e;
        e.src = src; e.pcw = pcw; e.irw = irw; e.mr = mr;
        e.epcw = epcw; e.lnk = lnk; e.exc = exc;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction class from the opcode map: 0 j, 1 jal, 2 branch, 3 jr, 4 rte, 5 datapath op, 6 illegal
    function automatic int cls(input logic [5:0] opc, input logic [5:0] fn);
        if (opc == 6'h00) begin
            if (fn == 6'h08) return 3;
            if (fn == 6'h13) return 4;
            return 5;
        end
        if (opc == 6'h02) return 0;
        if (opc == 6'h03) return 1;
        if (opc >= 6'h04 && opc <= 6'h07) return 2;
        if (opc inside {6'h08, 6'h09, 6'h0a, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b})
            return 5;
        return 6;
    endfunction

    // Single compare point per cycle, away from the active edge
    always @(negedge clk) begin
        if (exp_valid) begin
            exp_t act;
            act = {pc_source, pc_write, ir_write, mem_read, epc_write, link_write, exc_addr};
            tests++;
            if (act !== exp_cur) begin
                failed++;
                $display("FAIL %s cyc%0d: got src=%0d pcw=%0b irw=%0b mr=%0b epcw=%0b lnk=%0b exc=%0d, want src=%0d pcw=%0b irw=%0b mr=%0b epcw=%0b lnk=%0b exc=%0d",
                         tag, cycle_no, act.src, act.pcw, act.irw, act.mr, act.epcw, act.lnk, act.exc,
                         exp_cur.src, exp_cur.pcw, exp_cur.irw, exp_cur.mr, exp_cur.epcw,
                         exp_cur.lnk, exp_cur.exc);
            end
        end
    end

    // Named point check
    task automatic chk(input string name, input bit ok);
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL %s cyc%0d: src=%0d pcw=%0b irw=%0b mr=%0b epcw=%0b lnk=%0b exc=%0d",
                     name, cycle_no, pc_source, pc_write, ir_write, mem_read, epc_write,
                     link_write, exc_addr);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge and post its expectation
    task automatic cyc(input logic rst, input logic [5:0] opc, input logic [5:0] fn,
                       input logic z, input logic g, input logic ov, input logic dz,
                       input logic done, input exp_t e);
        @(posedge clk);
        #1;
        cycle_no++;
        reset = rst; opcode = opc; funct = fn; zero = z; gt = g;
        overflow = ov; div_zero = dz; op_done = done;
        exp_cur = e;
        exp_valid = 1'b1;
    endtask

    // Model-driven step; a planned abort replaces the step with a reset cycle
    task automatic step(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                        input logic g, input logic ov, input logic dz, input logic done,
                        input exp_t e);
        if (aborted) return;
        if (cur_idx == cur_abort) begin
            cyc(1'b1, opc, fn, rb(), rb(), rb(), rb(), rb(), mk(3'd0, 0, 0, 0, 0, 0, exc_model));
            exc_model = 8'd0;
            aborted = 1'b1;
        end else begin
            cyc(1'b0, opc, fn, z, g, ov, dz, done, e);
        end
        cur_idx++;
    endtask

    task automatic exc_seq(input logic [5:0] opc, input logic [5:0] fn);
        step(opc, fn, rb(), rb(), rb(), rb(), rb(), mk(3'd0, 0, 0, 1, 1, 0, exc_model));
        step(opc, fn, rb(), rb(), rb(), rb(), rb(), mk(3'd0, 0, 0, 1, 0, 0, exc_model));
        step(opc, fn, rb(), rb(), rb(), rb(), rb(), mk(3'd4, 1, 0, 0, 0, 0, exc_model));
    endtask

    task automatic run_instr();
        logic [5:0] opc, fn;
        logic [5:0] mem_ops [10];
        logic       z, g, taken;
        int         sel, c, nwait, endk;
        exp_t       ex;
        mem_ops = '{6'h08, 6'h09, 6'h0a, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b};
        sel = $urandom_range(0, 9);
        fn  = 6'($urandom_range(0, 63));
        case (sel)
            0, 1:    opc = 6'($urandom_range(0, 63));
            2:       opc = 6'h02;
            3:       opc = 6'h03;
            4, 5:    opc = 6'($urandom_range(4, 7));
            6: begin
                opc = 6'h00;
                c = $urandom_range(0, 2);
                if (c == 0) fn = 6'h08;
                else if (c == 1) fn = 6'h13;
            end
            default: opc = mem_ops[$urandom_range(0, 9)];
        endcase
        c = cls(opc, fn);
        cur_abort = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 1000;
        cur_idx = 0;
        aborted = 1'b0;
        tag = $sformatf("rand op=%02h fn=%02h", opc, fn);

        step(opc, fn, rb(), rb(), rb(), rb(), rb(), mk(3'd0, 0, 0, 1, 0, 0, exc_model));
        step(opc, fn, rb(), rb(), rb(), rb(), rb(), mk(3'd0, 0, 0, 1, 0, 0, exc_model));
        step(opc, fn, rb(), rb(), rb(), rb(), rb(), mk(3'd0, 1, 1, 0, 0, 0, exc_model));
        step(opc, fn, rb(), rb(), rb(), rb(), rb(), mk(3'd0, 0, 0, 0, 0, 0, exc_model));

        z = rb(); g = rb();
        ex = mk(3'd0, 0, 0, 0, 0, 0, exc_model);
        case (c)
            0: ex = mk(3'd2, 1, 0, 0, 0, 0, exc_model);
            1: ex = mk(3'd2, 1, 0, 0, 0, 1, exc_model);
            2: begin
                case (opc)
                    6'h04:   taken = z;
                    6'h05:   taken = !z;
                    6'h06:   taken = !g;
                    default: taken = g;
                endcase
                if (taken) ex = mk(3'd1, 1, 0, 0, 0, 0, exc_model);
            end
            3: ex = mk(3'd5, 1, 0, 0, 0, 0, exc_model);
            4: ex = mk(3'd3, 1, 0, 0, 0, 0, exc_model);
            default: ;
        endcase
        step(opc, fn, z, g, rb(), rb(), rb(), ex);

        if (c == 6) begin
            if (!aborted) exc_model = 8'd253;
            exc_seq(opc, fn);
        end else if (c == 5) begin
            nwait = $urandom_range(0, 4);
            for (int i = 0; i < nwait; i++)
                step(opc, fn, rb(), rb(), 1'b0, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, exc_model));
            endk = $urandom_range(0, 2);
            if (endk == 0)
                step(opc, fn, rb(), rb(), 1'b1, rb(), rb(), mk(3'd0, 0, 0, 0, 0, 0, exc_model));
            else if (endk == 1)
                step(opc, fn, rb(), rb(), 1'b0, 1'b1, rb(), mk(3'd0, 0, 0, 0, 0, 0, exc_model));
            else
                step(opc, fn, rb(), rb(), 1'b0, 1'b0, 1'b1, mk(3'd0, 0, 0, 0, 0, 0, exc_model));
            if (endk < 2) begin
                if (!aborted) exc_model = (endk == 0) ? 8'd254 : 8'd255;
                exc_seq(opc, fn);
            end
        end
    endtask

    // Literal fetch/decode prologue for directed cases
    task automatic lit_fetch(input logic [5:0] opc, input logic [5:0] fn, input logic [7:0] exc);
        cyc(0, opc, fn, 0, 0, 1, 1, 1, mk(3'd0, 0, 0, 1, 0, 0, exc));
        cyc(0, opc, fn, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 1, 0, 0, exc));
        cyc(0, opc, fn, 0, 0, 0, 0, 0, mk(3'd0, 1, 1, 0, 0, 0, exc));
        cyc(0, opc, fn, 0, 0, 1, 0, 1, mk(3'd0, 0, 0, 0, 0, 0, exc));
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 0; gt = 0;
        overflow = 0; div_zero = 0; op_done = 0;

        tag = "reset";
        cyc(1, 6'h04, 6'h00, 1, 0, 1, 1, 1, mk(3'd0, 0, 0, 0, 0, 0, 8'd0));
        cyc(1, 6'h04, 6'h00, 1, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd0));
        @(negedge clk);
        chk("reset_state", (exc_addr === 8'd0) && (pc_source === 3'd0) &&
            (pc_write === 1'b0) && (ir_write === 1'b0) && (mem_read === 1'b0) &&
            (epc_write === 1'b0) && (link_write === 1'b0));

        tag = "beq_taken";
        lit_fetch(6'h04, 6'h00, 8'd0);
        cyc(0, 6'h04, 6'h00, 1, 0, 1, 0, 1, mk(3'd1, 1, 0, 0, 0, 0, 8'd0));

        tag = "bne_untaken";
        lit_fetch(6'h05, 6'h00, 8'd0);
        cyc(0, 6'h05, 6'h00, 1, 1, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd0));

        tag = "jal";
        lit_fetch(6'h03, 6'h00, 8'd0);
        cyc(0, 6'h03, 6'h00, 0, 0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 1, 8'd0));

        tag = "ovf_over_done";
        lit_fetch(6'h00, 6'h20, 8'd0);
        cyc(0, 6'h00, 6'h20, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd0));
        for (int i = 0; i < 3; i++)
            cyc(0, 6'h00, 6'h20, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd0));
        @(negedge clk);
        chk("expired_wait", (pc_write === 1'b0) && (ir_write === 1'b0) &&
            (mem_read === 1'b0) && (epc_write === 1'b0) && (pc_source === 3'd0) &&
            (exc_addr === 8'd0));
        cyc(0, 6'h00, 6'h20, 0, 0, 1, 0, 1, mk(3'd0, 0, 0, 0, 0, 0, 8'd0));
        cyc(0, 6'h00, 6'h20, 0, 0, 0, 0, 1, mk(3'd0, 0, 0, 1, 1, 0, 8'd254));
        cyc(0, 6'h00, 6'h20, 0, 0, 0, 0, 1, mk(3'd0, 0, 0, 1, 0, 0, 8'd254));
        cyc(0, 6'h00, 6'h20, 0, 0, 0, 0, 1, mk(3'd4, 1, 0, 0, 0, 0, 8'd254));

        tag = "illegal";
        lit_fetch(6'h3f, 6'h00, 8'd254);
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd254));
        cyc(0, 6'h3f, 6'h00, 0, 0, 1, 1, 1, mk(3'd0, 0, 0, 1, 1, 0, 8'd253));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 1, 0, 0, 8'd253));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd4, 1, 0, 0, 0, 0, 8'd253));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 1, 0, 0, 8'd253));

        tag = "reset_in_exc_wait";
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 1, 0, 0, 8'd253));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 1, 1, 0, 0, 0, 8'd253));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd253));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd253));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 1, 1, 0, 8'd253));
        cyc(1, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd253));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 1, 0, 0, 8'd0));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 1, 0, 0, 8'd0));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 1, 1, 0, 0, 0, 8'd0));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd0));
        cyc(0, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd0));
        cyc(1, 6'h3f, 6'h00, 0, 0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 8'd253));

        exc_model = 8'd0;
        for (int n = 0; n < 300; n++)
            run_instr();

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pc_flow_ctrl.md
PC_FLOW_CTRL -- requirements
Module: pc_flow_ctrl

Interface
REQ-001 Parameters: EXC_ILLEGAL_ADDR, default 8'd253, vector-byte address for illegal opcode.
REQ-002 Parameters: EXC_OVF_ADDR, default 8'd254, vector-byte address for arithmetic overflow.
REQ-003 Parameters: EXC_DIV0_ADDR, default 8'd255, vector-byte address for divide-by-zero.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports, one per line:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXEC
- gt  in  1  ALU greater-than flag, valid in EXEC
- overflow  in  1  datapath overflow, sampled in WAIT_OP
- div_zero  in  1  divider zero-divisor flag, sampled in WAIT_OP
- op_done  in  1  datapath finished a non-flow instruction
- pc_source  out  3  PC mux select: 000 PC+4, 001 ALUOut branch target, 010 jump target, 011 EPC, 100 vector byte, 101 register A
- pc_write  out  1  PC load strobe
- ir_write  out  1  IR load strobe
- mem_read  out  1  memory read request
- epc_write  out  1  EPC load strobe (EPC <= PC-4, computed externally)
- link_write  out  1  write PC into $ra (jal)
- exc_addr  out  8  memory byte address for vector fetch

Function
REQ-006 States: FETCH0, FETCH1, FETCH2, DECODE, EXEC, WAIT_OP, EXC_EPC, EXC_WAIT, EXC_LOAD; binary-encoded, 4-bit state register.
REQ-007 All strobe outputs SHALL be combinational from state and inputs; exc_addr SHALL be registered and held until the next exception.
REQ-008 pc_source SHALL be 000 in every cycle where pc_write=0.
REQ-009 FETCH0, FETCH1: mem_read=1; FETCH0->FETCH1->FETCH2 unconditionally (two-cycle memory latency).
REQ-010 FETCH2: ir_write=1, pc_write=1, pc_source=000; next state DECODE.
REQ-011 DECODE: no strobes; next state EXEC.
REQ-012 EXEC, opcode 0x02 (j): pc_write=1, pc_source=010; next FETCH0.
REQ-013 EXEC, opcode 0x03 (jal): pc_write=1, pc_source=010, link_write=1; next FETCH0.
REQ-014 EXEC, 0x04 beq / 0x05 bne / 0x06 ble / 0x07 bgt: pc_write=1, pc_source=001 iff zero / !zero / !gt / gt respectively; next FETCH0 regardless of outcome.
REQ-015 EXEC, opcode 0x00 funct 0x08 (jr): pc_write=1, pc_source=101; funct 0x13 (rte): pc_write=1, pc_source=011; next FETCH0.
REQ-016 EXEC, other R-type funct or opcode in {0x08,0x09,0x0a,0x0f,0x20,0x21,0x23,0x28,0x29,0x2b}: no strobes; next WAIT_OP.
REQ-017 EXEC, any other opcode: exc_addr<=EXC_ILLEGAL_ADDR; next EXC_EPC.
REQ-018 WAIT_OP priority: overflow (exc_addr<=EXC_OVF_ADDR, ->EXC_EPC) over div_zero (exc_addr<=EXC_DIV0_ADDR, ->EXC_EPC) over op_done (->FETCH0); none asserted: stay, unbounded.
REQ-019 EXC_EPC: epc_write=1, mem_read=1; next EXC_WAIT.
REQ-020 EXC_WAIT: mem_read=1; next EXC_LOAD.
REQ-021 EXC_LOAD: pc_write=1, pc_source=100; next FETCH0.
REQ-022 overflow, div_zero and op_done SHALL be ignored in all states except WAIT_OP.
REQ-023 Exactly one pc_write pulse per FETCH2, and at most one more per instruction.

Reset
REQ-024 reset=1 at a rising edge SHALL force state FETCH0 and exc_addr=8'd0, overriding every transition.
REQ-025 While reset=1 all strobes SHALL be 0 and pc_source=000.
REQ-026 Reset in any state, including EXC_EPC..EXC_LOAD, SHALL abort with no further pc_write or epc_write.

Verification
REQ-027 Release reset, opcode=0x04, zero=1 -> mem_read cycles 1-2, pc_write/ir_write cycle 3 (src 000), pc_write src 001 cycle 5, FETCH0 cycle 6.
REQ-028 opcode=0x05, zero=1 -> EXEC has pc_write=0, pc_source=000; next state FETCH0.
REQ-029 opcode=0x00 funct=0x20, overflow=1 and op_done=1 same cycle in WAIT_OP -> exc_addr=254, epc_write next cycle, pc_write src 100 two cycles later.
REQ-030 opcode=0x3f -> exc_addr=253, EXC_EPC/EXC_WAIT/EXC_LOAD sequence, then FETCH0.
REQ-031 opcode=0x03 -> pc_write=1, pc_source=010, link_write=1 single cycle in EXEC.
REQ-032 reset asserted in EXC_WAIT -> no pc_write, next state FETCH0, exc_addr=0.
